// File: rtl/mvm_run_sequencer.sv
// Run sequencer for the MVM core: pulses start_input/start_inst, collects per-channel completion,
// enforces a per-run timeout and repeats for a batch of runs or until aborted.
module mvm_run_sequencer #(
    parameter int unsigned NUM_CH         = 1,
    parameter int unsigned RUN_W          = 8,
    parameter int unsigned GAP_CYCLES     = 1,
    parameter int unsigned SETTLE_CYCLES  = 10,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic              abort,
    input  logic              loop_en,
    input  logic [RUN_W-1:0]  num_runs,
    input  logic [NUM_CH-1:0] data_received,
    output logic              start_input,
    output logic              start_inst,
    output logic              busy,
    output logic              done,
    output logic [RUN_W-1:0]  run_count,
    output logic [RUN_W-1:0]  err_count,
    output logic              timeout_err
);

    localparam int unsigned CNT_MAX0 = (GAP_CYCLES > SETTLE_CYCLES) ? GAP_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > TIMEOUT_CYCLES) ? CNT_MAX0 : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W    = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    localparam logic [2:0] StIdle      = 3'd0;
    localparam logic [2:0] StInPulse   = 3'd1;
    localparam logic [2:0] StGap       = 3'd2;
    localparam logic [2:0] StInstPulse = 3'd3;
    localparam logic [2:0] StWait      = 3'd4;
    localparam logic [2:0] StSettle    = 3'd5;
    localparam logic [2:0] StDone      = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [RUN_W-1:0]  run_count_q, run_count_d;
    logic [RUN_W-1:0]  err_count_q, err_count_d;
    logic              timeout_err_q, timeout_err_d;
    logic [RUN_W-1:0]  num_runs_q, num_runs_d;
    logic              loop_en_q, loop_en_d;

    logic [31:0]       cnt_next;
    logic [RUN_W-1:0]  run_inc;
    logic              run_end;
    logic [2:0]        after_settle;

    assign cnt_next = 32'(cnt_q) + 32'd1;
    assign run_inc  = run_count_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mask_d        = mask_q;
        run_count_d   = run_count_q;
        err_count_d   = err_count_q;
        timeout_err_d = timeout_err_q;
        num_runs_d    = num_runs_q;
        loop_en_d     = loop_en_q;
        run_end       = 1'b0;
        after_settle  = StIdle;

        if (abort) begin
            state_d = StIdle;
            mask_d  = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (go) begin
                        num_runs_d    = num_runs;
                        loop_en_d     = loop_en;
                        run_count_d   = '0;
                        err_count_d   = '0;
                        timeout_err_d = 1'b0;
                        state_d = (num_runs == '0 && !loop_en) ? StDone : StInPulse;
                    end
                end
                StInPulse: begin
                    mask_d  = data_received;
                    cnt_d   = '0;
                    state_d = (GAP_CYCLES > 0) ? StGap : StInstPulse;
                end
                StGap: begin
                    mask_d = mask_q | data_received;
                    if (cnt_next == GAP_CYCLES) begin
                        cnt_d   = '0;
                        state_d = StInstPulse;
                    end else begin
                        cnt_d = CNT_W'(cnt_next);
                    end
                end
                StInstPulse: begin
                    mask_d  = mask_q | data_received;
                    cnt_d   = '0;
                    state_d = StWait;
                end
                StWait: begin
                    mask_d = mask_q | data_received;
                    // Completion is checked first so it wins over a coincident timeout.
                    if (&(mask_q | data_received)) begin
                        run_count_d = run_inc;
                        run_end     = 1'b1;
                    end else if (cnt_next == TIMEOUT_CYCLES) begin
                        run_count_d   = run_inc;
                        timeout_err_d = 1'b1;
                        if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
                        run_end       = 1'b1;
                    end else begin
                        cnt_d = CNT_W'(cnt_next);
                    end
                    if (run_end) begin
                        cnt_d = '0;
                        if (SETTLE_CYCLES == 0) begin
                            state_d = (loop_en_q || run_inc != num_runs_q) ? StInPulse : StDone;
                        end else begin
                            state_d = StSettle;
                        end
                    end
                end
                StSettle: begin
                    after_settle = (loop_en_q || run_count_q != num_runs_q) ? StInPulse : StDone;
                    if (cnt_next >= SETTLE_CYCLES) begin
                        cnt_d   = '0;
                        state_d = after_settle;
                    end else begin
                        cnt_d = CNT_W'(cnt_next);
                    end
                end
                StDone: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            mask_q        <= '0;
            run_count_q   <= '0;
            err_count_q   <= '0;
            timeout_err_q <= 1'b0;
            num_runs_q    <= '0;
            loop_en_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mask_q        <= mask_d;
            run_count_q   <= run_count_d;
            err_count_q   <= err_count_d;
            timeout_err_q <= timeout_err_d;
            num_runs_q    <= num_runs_d;
            loop_en_q     <= loop_en_d;
        end
    end

    // Outputs decode straight from state so an asynchronous reset clears them at once.
    assign start_input = (state_q == StInPulse);
    assign start_inst  = (state_q == StInstPulse);
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign run_count   = run_count_q;
    assign err_count   = err_count_q;
    assign timeout_err = timeout_err_q;

endmodule
